// File: rtl/logic16_arbiter.sv
// logic16_arbiter: round-robin arbiter sharing one bitwise logic unit
// (AND / OR / XOR / NOT) between N_REQ requesters.
//
// Ports:
//   clk, rst_n  - system clock (rising edge), asynchronous active-low reset
//   req         - per-requester request level
//   op_flat     - per-requester opcode, requester i at [2i+1:2i]
//   a_flat      - per-requester operand A, requester i at slice i
//   b_flat      - per-requester operand B, requester i at slice i
//   gnt         - registered one-hot grant pulse (one cycle)
//   rsp_valid   - result available; held until rsp_ready
//   rsp_ready   - consumer accepts the result
//   rsp_id      - requester that owns rsp_data
//   rsp_data    - result
//   busy        - high whenever the FSM is not idle
//
// Operation: IDLE samples req and captures the winner's operands (gnt is high
// during the following EXEC cycle), EXEC registers the result, RESP holds it
// until accepted. The round-robin pointer moves past the winner only once the
// response has been consumed.
module logic16_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op_flat,
  input  logic [WIDTH*N_REQ-1:0] a_flat,
  input  logic [WIDTH*N_REQ-1:0] b_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [ID_W-1:0] LastId = ID_W'(N_REQ - 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [1:0]       op_cap;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  logic [1:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = op_flat[2*g +: 2];
    assign a_arr[g]  = a_flat[WIDTH*g +: WIDTH];
    assign b_arr[g]  = b_flat[WIDTH*g +: WIDTH];
  end

  // Round-robin search: walk candidates ptr, ptr+1, ... wrapping at N_REQ-1.
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == LastId) ? '0 : cand + 1'b1;
    end
  end

  logic [WIDTH-1:0] result;

  always_comb begin
    result = '0;
    case (op_cap)
      2'b00:   result = a_cap & b_cap;
      2'b01:   result = a_cap | b_cap;
      2'b10:   result = a_cap ^ b_cap;
      default: result = ~a_cap;
    endcase
  end

  logic [ID_W-1:0] ptr_next;
  assign ptr_next = (rsp_id == LastId) ? '0 : rsp_id + 1'b1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_cap    <= '0;
      a_cap     <= '0;
      b_cap     <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op_cap <= op_arr[win];
            a_cap  <= a_arr[win];
            b_cap  <= b_arr[win];
            gnt    <= N_REQ'(1) << win;
            rsp_id <= win;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt       <= '0;
          rsp_data  <= result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_next;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed self-checking bench for logic16_arbiter (N_REQ=4, WIDTH=16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_logic16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op_flat = '0;
  logic [63:0] a_flat = '0;
  logic [63:0] b_flat = '0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic16_arbiter #(.N_REQ(4), .WIDTH(16), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_flat   (op_flat),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_opnd(input int id, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    op_flat[2*id +: 2] = op;
    a_flat[16*id +: 16] = a;
    b_flat[16*id +: 16] = b;
  endtask

  // Single operation with immediate ready; checks grant, response, completion.
  task automatic do_op(input string tag, input int id, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    set_opnd(id, op, a, b);
    rsp_ready = 1'b1;
    req = onehot;
    step();
    chk({tag, "_gnt"}, gnt, onehot);
    req = '0;
    step();
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, id[1:0]);
    chk({tag, "_data"}, rsp_data, exp);
    step();
    chk({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ngr;
    int last;
    int waited;
    logic [15:0] held_data;

    // Reset state
    #3;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);

    // First transaction: OR on requester 0
    set_opnd(0, 2'b01, 16'h0000, 16'hFFFF);
    rsp_ready = 1'b1;
    req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_busy_gnt", busy, 1'b1);
    chk("t1_valid_early", rsp_valid, 1'b0);
    req = '0;
    step();
    chk("t1_gnt_drop", gnt, 4'b0000);
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 2'd0);
    chk("t1_data", rsp_data, 16'hFFFF);
    chk("t1_busy_resp", busy, 1'b1);
    step();
    chk("t1_valid_done", rsp_valid, 1'b0);
    chk("t1_busy_done", busy, 1'b0);

    // All opcodes on requester 2
    do_op("and", 2, 2'b00, 16'hA38C, 16'hC707, 16'h8304);
    do_op("or",  2, 2'b01, 16'hA38C, 16'hC707, 16'hE78F);
    do_op("xor", 2, 2'b10, 16'hA38C, 16'hC707, 16'h648B);
    do_op("not", 2, 2'b11, 16'hA38C, 16'hC707, 16'h5C73);

    // All requesters held high from ptr=0: rotation 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_opnd(i, 2'b10, 16'h1111 * i, 16'h0F0F);
    rsp_ready = 1'b1;
    req = 4'b1111;
    ngr = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
      step();
      if (gnt != 4'b0000) begin
        chk("rr_onehot", $onehot(gnt), 1);
        chk("rr_order", gnt, 4'b0001 << (ngr % 4));
        if (ngr > 0) chk("rr_gap", cyc - last, 3);
        last = cyc;
        ngr++;
      end
    end
    chk("rr_count", ngr, 5);
    req = '0;
    waited = 0;
    while (busy && waited < 10) begin
      step();
      waited++;
    end
    chk("rr_drain", busy, 1'b0);

    // Backpressure: requester 2 wins (ptr=1), others pending while response held
    set_opnd(2, 2'b00, 16'hF0F0, 16'h3C3C);
    rsp_ready = 1'b0;
    req = 4'b0100;
    step();
    chk("bp_gnt", gnt, 4'b0100);
    req = 4'b1010;
    step();
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_id", rsp_id, 2'd2);
    chk("bp_data", rsp_data, 16'h3030);
    held_data = rsp_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_id", rsp_id, 2'd2);
      chk("bp_hold_data", rsp_data, held_data);
      chk("bp_no_gnt", gnt, 4'b0000);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_accept", rsp_valid, 1'b0);
    step();
    chk("bp_next_gnt", gnt, 4'b1000);
    req = '0;
    step();
    chk("bp_next_id", rsp_id, 2'd3);
    step();
    chk("bp_next_done", busy, 1'b0);

    // Operand change after capture has no effect (ptr=0, requester 1 wins)
    set_opnd(1, 2'b01, 16'h00FF, 16'h0000);
    req = 4'b0010;
    step();
    chk("cap_gnt", gnt, 4'b0010);
    a_flat[31:16] = 16'hFFFF;
    req = '0;
    step();
    chk("cap_data", rsp_data, 16'h00FF);
    step();

    // Asynchronous reset while holding a response
    set_opnd(2, 2'b11, 16'h1234, 16'h0000);
    rsp_ready = 1'b0;
    req = 4'b0100;
    step();
    req = '0;
    step();
    chk("ar_valid_before", rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", rsp_valid, 1'b0);
    chk("ar_gnt", gnt, 4'b0000);
    chk("ar_busy", busy, 1'b0);
    chk("ar_data", rsp_data, 16'h0000);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_no_rsp", rsp_valid, 1'b0);
      chk("ar_idle", busy, 1'b0);
    end
    set_opnd(0, 2'b00, 16'hFFFF, 16'h5A5A);
    set_opnd(3, 2'b00, 16'h0000, 16'h0000);
    req = 4'b1001;
    step();
    chk("ar_first_gnt", gnt, 4'b0001);
    req = '0;
    step();
    chk("ar_first_data", rsp_data, 16'h5A5A);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
